// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Sequencer and two-port round-robin arbiter in front of a shared 8-bit ALU.
//   Two clients issue 16-bit operations. The block grants one request at a
//   time and runs add/sub/and/or as a low-byte pass followed by a high-byte
//   pass. A signed less-than runs as a multi-step byte compare. Each
//   completion returns a registered 16-bit result, flags and a one-cycle done
//   pulse to the client that owns the operation.
//
// Ports:
//   i_clock               single clock, all state changes on posedge
//   i_reset_n             asynchronous active-low reset
//   i_req0/i_req1         request level per client, held until done
//   i_op0/i_op1           opcode per client (AC_* codes)
//   i_a0/i_b0/i_a1/i_b1   16-bit operands per client
//   o_done0/o_done1       one-cycle completion pulse to the owning client
//   o_result              result of the last completed operation
//   o_zero/o_carry        flags of the last completed operation
//   o_compare             less-than outcome of the last completed operation
//   o_owner               client index that owns o_result
//   o_busy                high whenever the sequencer is not idle
//   o_alu_cs/o_alu_a/o_alu_b/o_alu_cin   drive to the shared ALU
//   i_alu_s/i_alu_zero/i_alu_cout        ALU result and flags
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter logic [2:0] AC_AD = 3'd0,
  parameter logic [2:0] AC_SB = 3'd1,
  parameter logic [2:0] AC_AN = 3'd2,
  parameter logic [2:0] AC_OR = 3'd3,
  parameter logic [2:0] AC_LS = 3'd4
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic [2:0]  i_op0,
  input  logic [2:0]  i_op1,
  input  logic [15:0] i_a0,
  input  logic [15:0] i_b0,
  input  logic [15:0] i_a1,
  input  logic [15:0] i_b1,
  output logic        o_done0,
  output logic        o_done1,
  output logic [15:0] o_result,
  output logic        o_zero,
  output logic        o_carry,
  output logic        o_compare,
  output logic        o_owner,
  output logic        o_busy,
  output logic [2:0]  o_alu_cs,
  output logic [7:0]  o_alu_a,
  output logic [7:0]  o_alu_b,
  output logic        o_alu_cin,
  input  logic [7:0]  i_alu_s,
  input  logic        i_alu_zero,
  input  logic        i_alu_cout
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_LSH  = 3'd3,
    S_LSHR = 3'd4,
    S_LSL  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  // Any code outside the supported set runs as AND.
  function automatic logic [2:0] map_op(input logic [2:0] op);
    if (op == AC_AD || op == AC_SB || op == AC_OR || op == AC_LS) begin
      return op;
    end
    return AC_AN;
  endfunction

  state_t      r_state;
  state_t      w_state_next;

  // Latched request
  logic        r_last;
  logic        r_own;
  logic [2:0]  r_op;
  logic [15:0] r_a;
  logic [15:0] r_b;

  // Staging between the low and high byte passes
  logic [7:0]  r_res_lo;
  logic        r_zero_lo;
  logic        r_carry_stg;

  // Visible completion registers
  logic [15:0] r_result;
  logic        r_zero;
  logic        r_carry;
  logic        r_compare;
  logic        r_owner;

  // Combinational decode
  logic        w_grant;
  logic        w_gidx;
  logic [2:0]  w_gop;
  logic        w_ls_fin;
  logic        w_cmp;
  logic [2:0]  w_alu_cs;
  logic [7:0]  w_alu_a;
  logic [7:0]  w_alu_b;
  logic        w_alu_cin;

  // State register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, grant decision and ALU drive
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_gidx       = 1'b0;
    w_gop        = AC_AN;
    w_ls_fin     = 1'b0;
    w_cmp        = 1'b0;
    w_alu_cs     = AC_AN;
    w_alu_a      = 8'h00;
    w_alu_b      = 8'h00;
    w_alu_cin    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_req0 || i_req1) begin
          w_grant = 1'b1;
          // Contention goes to the client that was not served last.
          if (i_req0 && i_req1) begin
            w_gidx = ~r_last;
          end else begin
            w_gidx = i_req1;
          end
          w_gop = map_op(w_gidx ? i_op1 : i_op0);
          w_state_next = (w_gop == AC_LS) ? S_LSH : S_LO;
        end
      end

      S_LO: begin
        w_alu_cs     = r_op;
        w_alu_a      = r_a[7:0];
        w_alu_b      = r_b[7:0];
        w_state_next = S_HI;
      end

      S_HI: begin
        w_alu_cs     = r_op;
        w_alu_a      = r_a[15:8];
        w_alu_b      = r_b[15:8];
        w_alu_cin    = r_carry_stg;
        w_state_next = S_DONE;
      end

      S_LSH: begin
        w_alu_cs = AC_LS;
        w_alu_a  = r_a[15:8];
        w_alu_b  = r_b[15:8];
        if (r_a[15] ^ r_b[15]) begin
          // Signs differ: the negative operand is the smaller one.
          w_ls_fin     = 1'b1;
          w_cmp        = r_a[15];
          w_state_next = S_DONE;
        end else if (i_alu_s[0]) begin
          w_ls_fin     = 1'b1;
          w_cmp        = 1'b1;
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_LSHR;
        end
      end

      S_LSHR: begin
        // Reverse compare of the high bytes separates "greater" from "equal".
        w_alu_cs = AC_LS;
        w_alu_a  = r_b[15:8];
        w_alu_b  = r_a[15:8];
        if (i_alu_s[0]) begin
          w_ls_fin     = 1'b1;
          w_cmp        = 1'b0;
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_LSL;
        end
      end

      S_LSL: begin
        w_alu_cs     = AC_LS;
        w_alu_a      = r_a[7:0];
        w_alu_b      = r_b[7:0];
        w_ls_fin     = 1'b1;
        w_cmp        = i_alu_s[0];
        w_state_next = S_DONE;
      end

      S_DONE: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Request latch, byte staging and completion registers
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_last      <= 1'b1;
      r_own       <= 1'b0;
      r_op        <= AC_AN;
      r_a         <= 16'h0000;
      r_b         <= 16'h0000;
      r_res_lo    <= 8'h00;
      r_zero_lo   <= 1'b0;
      r_carry_stg <= 1'b0;
      r_result    <= 16'h0000;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_compare   <= 1'b0;
      r_owner     <= 1'b0;
    end else begin
      if (w_grant) begin
        r_last <= w_gidx;
        r_own  <= w_gidx;
        r_op   <= w_gop;
        r_a    <= w_gidx ? i_a1 : i_a0;
        r_b    <= w_gidx ? i_b1 : i_b0;
      end

      if (r_state == S_LO) begin
        r_res_lo    <= i_alu_s;
        r_zero_lo   <= i_alu_zero;
        r_carry_stg <= i_alu_cout;
      end

      // The visible result only changes on entry to DONE, so a client never
      // sees a half-written value.
      if (r_state == S_HI) begin
        r_result  <= {i_alu_s, r_res_lo};
        r_zero    <= r_zero_lo & i_alu_zero;
        r_carry   <= i_alu_cout;
        r_compare <= 1'b0;
        r_owner   <= r_own;
      end

      if (w_ls_fin) begin
        r_result  <= {15'b0, w_cmp};
        r_zero    <= 1'b0;
        r_carry   <= 1'b0;
        r_compare <= w_cmp;
        r_owner   <= r_own;
      end
    end
  end

  assign o_done0   = (r_state == S_DONE) && !r_own;
  assign o_done1   = (r_state == S_DONE) &&  r_own;
  assign o_busy    = (r_state != S_IDLE);
  assign o_result  = r_result;
  assign o_zero    = r_zero;
  assign o_carry   = r_carry;
  assign o_compare = r_compare;
  assign o_owner   = r_owner;
  assign o_alu_cs  = w_alu_cs;
  assign o_alu_a   = w_alu_a;
  assign o_alu_b   = w_alu_b;
  assign o_alu_cin = w_alu_cin;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencer and two-port arbiter for the shared 8-bit `alu`. It accepts 16-bit operation requests from two clients, for example the keypad calculator path and a second consumer. It grants one request at a time using round-robin, runs the operation on the 8-bit ALU as low/high byte slices (or as a multi-step signed compare), and returns a registered 16-bit result with flags and a one-cycle done pulse to the owning client. It sits between the requesters and the `alu` instance and is the only driver of the ALU's inputs.

## Interface
- `AC_AD`, default 3'd0: ALU CS code for add.
- `AC_SB`, default 3'd1: ALU CS code for subtract.
- `AC_AN`, default 3'd2: ALU CS code for AND.
- `AC_OR`, default 3'd3: ALU CS code for OR.
- `AC_LS`, default 3'd4: ALU CS code for unsigned less-than; the ALU returns S[0]=1 when a<b.
- `Clock`  in  1  the single clock; all state changes on posedge.
- `Reset`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  request level per client; must be held until the matching done.
- `op0`, `op1`  in  3  opcode per client, one of the AC_* codes.
- `a0`, `b0`, `a1`, `b1`  in  16  operands per client.
- `done0`, `done1`  out  1  one-cycle completion pulse to the owning client.
- `result`  out  16  result of the last completed operation.
- `zero`, `carry`, `compare`  out  1  flags of the last completed operation.
- `owner`  out  1  index of the client that owns `result`.
- `busy`  out  1  high whenever the state is not IDLE.
- `alu_cs`  out  3  CS driven to the ALU.
- `alu_a`, `alu_b`  out  8  ALU operands.
- `alu_cin`  out  1  ALU carry in.
- `alu_s`  in  8  ALU result.
- `alu_zero`, `alu_cout`  in  1  ALU flags.

## Operation
- **States:** IDLE, LO, HI, LSH, LSHR, LSL, DONE.
- **IDLE:**
  - With a single request pending, that client is granted.
  - With both pending, the client other than `last` is granted; `last` resets to 1, so client 0 wins first.
  - On grant, latch op, a, b and owner, and set `last` to the granted client. Go to LS-type state LSH if op==AC_LS, otherwise to LO.
  - An op code outside the AC_* set is treated as AC_AN.
- **LO:** drive a[7:0], b[7:0], cin=0, cs=op. Capture S into result[7:0], zero_lo=alu_zero, and carry=alu_cout. Go to HI.
- **HI:** drive a[15:8], b[15:8], cin=carry, cs=op. Capture result[15:8], zero=zero_lo&&alu_zero, carry=alu_cout, compare=0. Go to DONE.
- **LSH:**
  - If a[15]^b[15], set compare=a[15] and go to DONE without using the ALU.
  - Otherwise drive a_hi/b_hi with cs=AC_LS, cin=0. If S[0]=1, set compare=1 and go to DONE; otherwise go to LSHR.
- **LSHR:** drive b_hi as alu_a and a_hi as alu_b. If S[0]=1, set compare=0 and go to DONE; otherwise go to LSL.
- **LSL:** drive a_lo/b_lo with cs=AC_LS. Set compare=S[0] and go to DONE.
- **LS result:** for all LS paths, result={15'b0,compare}, zero=0, carry=0.
- **DONE:** pulse done[owner] for this cycle, then return to IDLE.
- **Outputs outside DONE:** result, flags and owner hold until the next completion overwrites them. No partial-result visibility: result, zero and carry are written from staging registers on the transition into DONE.
- **IDLE ALU drive:** when IDLE, alu_cs=AC_AN, alu_a=0, alu_b=0, alu_cin=0 (no X).
- **Request drop:** deasserting a req after grant does not abort; the operation completes and the done pulse is still issued.
- **Back-to-back requests:** a client still holding req in the cycle after its done may be regranted. Round-robin guarantees that a waiting client is granted next.

## Timing
- **Reset (async, Reset=0):**
  - State=IDLE, last=1.
  - result=0; zero, carry, compare=0; owner=0.
  - done0, done1, busy=0.
  - ALU outputs at their IDLE values.
  - An in-flight operation is discarded with no done pulse.
- **Grant:** a request sampled at edge N moves to LO/LSH at N, so busy is high from after N.
- **Arithmetic latency:** LO at N+1, HI at N+2, DONE cycle N+2..N+3. The done pulse is 3 cycles after the sampling edge.
- **LS latency:**
  - Sign-differ path: done after 2 cycles.
  - High-byte decided: 2 cycles (LSH) or 3 cycles (LSHR).
  - Full compare: 4 cycles.
- **Minimum spacing:** a new grant can occur at the edge ending DONE+1, i.e. one IDLE cycle between operations.
- **Combinational drive:** ALU inputs are combinational from state and the latched operands. ALU outputs are captured on the edge that leaves the state.

## Test plan
- req0 with AD, a0=0x01FF, b0=0x0001 -> done0 3 cycles later; result=0x0200, carry=0, zero=0, owner=0.
- req1 with AD, a1=0xFFFF, b1=0x0001 -> result=0x0000, zero=1, carry=1; done1 only, done0 stays 0.
- LS compares -> all complete with the stated latency, zero=0, carry=0:
  - a=0xFFFF, b=0x0001: compare=1 via the sign path, 2 cycles.
  - a=0x0102, b=0x0105: compare=1 via LSL, 4 cycles.
  - a=0x0200, b=0x0105: compare=0 via LSHR.
- req0 and req1 asserted in the same cycle and held for 4 operations -> grants alternate 0,1,0,1; each done matches its requester's operands.
- Reset pulled low during HI of an AD op -> no done; all outputs return to reset values immediately. The next request after release completes normally.
- req0 dropped the cycle after grant with OR, a=0xF0F0, b=0x0F0F -> operation still completes with result=0xFFFF and a done0 pulse. The ALU sees cs=AC_AN with operands 0 while IDLE.
